// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: issue/capture sequencer for the 32x32 signed/unsigned multiplier pair.
// Holds operands steady for SETTLE_CYCLES clocks, then captures the selected product into HI/LO.
module mult_seq_ctrl #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic        SIGNED,
   input  logic [31:0] A_IN,
   input  logic [31:0] B_IN,
   input  logic        ACK,
   output logic [31:0] OP_A,
   output logic [31:0] OP_B,
   input  logic [31:0] S_HI,
   input  logic [31:0] S_LO,
   input  logic [31:0] U_HI,
   input  logic [31:0] U_LO,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sgn_q, sgn_d;
   logic [31:0]       opa_q, opa_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
   logic              accept;
   assign accept = START && (state_q == ST_IDLE || (state_q == ST_DONE && ACK));
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (accept) begin
         state_d = ST_SETTLE;
         cnt_d   = RELOAD;
         sgn_d   = SIGNED;
         opa_d   = A_IN;
         opb_d   = B_IN;
      end else if (state_q == ST_SETTLE) begin
         // counter only counts down here; it is reloaded solely on an accepted START
         if (cnt_q == '0) begin
            state_d = ST_DONE;
            hi_d    = sgn_q ? S_HI : U_HI;
            lo_d    = sgn_q ? S_LO : U_LO;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end else if (state_q == ST_DONE && ACK) begin
         state_d = ST_IDLE;
      end
   end
   assign BUSY = (state_q == ST_SETTLE);
   assign DONE = (state_q == ST_DONE);
   assign OP_A = opa_q;
   assign OP_B = opb_q;
   assign HI   = hi_q;
   assign LO   = lo_q;
endmodule
